// File: rtl/uart_tx_driver_if.sv
// Byte handshake bundle between a byte producer and the UART transmitter.
// Latency: none, wires only.
// Backpressure: the producer holds data_out/data_out_valid until data_out_ready is seen high at a clock edge.
//
// Ports:
//   data_out        byte to transmit (producer -> transmitter)
//   data_out_valid  data_out holds a byte this cycle (producer -> transmitter)
//   data_out_ready  transmitter FIFO can take a byte (transmitter -> producer)
interface uart_tx_driver_if #(
  parameter int BYTE_WIDTH = 8
);
  logic [BYTE_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;

  modport master (
    output data_out,
    output data_out_valid,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output data_out_ready
  );
endinterface

// File: rtl/uart_tx_driver.sv
// UART transmitter: byte FIFO in front of a start/data/stop serialiser, idle-high line.
// Latency: a byte accepted at edge N is popped at N+1, and the line goes low after edge N+2.
// Backpressure: data_out_ready = FIFO not full; a full FIFO stalls the producer until a byte is popped.
//
// Ports:
//   clock_50_000_000  system clock, all logic on posedge
//   reset_l           async active-low reset; abandons any frame and empties the FIFO
//   byte_if           slave side of the byte handshake (data_out/_valid/_ready)
//   uart_tx           registered serial output, idle high
//   busy              a frame is in flight or bytes are still queued
module uart_tx_driver #(
  parameter int BAUD_RATE  = 31250,
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BYTE_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock_50_000_000,
  input  logic              reset_l,
  uart_tx_driver_if.slave   byte_if,
  output logic              uart_tx,
  output logic              busy
);

  localparam int BIT_TICKS = CLOCK_HZ / BAUD_RATE;
  localparam int TICK_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int BIT_W     = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [BYTE_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = byte_if.data_out_valid & ~w_full;
  assign byte_if.data_out_ready = ~w_full;

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clock_50_000_000) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= byte_if.data_out;
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_nxt;
  logic [TICK_W-1:0]     r_tick;
  logic [BIT_W-1:0]      r_bit_idx;
  logic [BYTE_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic                  w_tick_done;
  logic                  w_last_bit;
  logic                  w_data_bit;
  logic                  w_tx_nxt;
  logic                  w_busy;

  assign w_tick_done = (r_tick >= TICK_W'(BIT_TICKS - 1));
  assign w_last_bit  = (r_bit_idx == BIT_W'(BYTE_WIDTH - 1));
  assign w_data_bit  = MSB_FIRST ? r_shift[BYTE_WIDTH-1] : r_shift[0];

  // State register
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_START;
      S_START: if (w_tick_done) w_state_nxt = S_DATA;
      S_DATA:  if (w_tick_done && w_last_bit) w_state_nxt = S_STOP;
      S_STOP:  if (w_tick_done) w_state_nxt = w_empty ? S_IDLE : S_START;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic. The line value is registered one clock behind the state, so
  // every bit on uart_tx still lasts exactly BIT_TICKS clocks.
  always_comb begin
    w_pop    = 1'b0;
    w_tx_nxt = 1'b1;
    w_busy   = ~w_empty;
    case (r_state)
      S_IDLE: begin
        w_pop = ~w_empty;
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        w_busy   = 1'b1;
      end
      S_DATA: begin
        w_tx_nxt = w_data_bit;
        w_busy   = 1'b1;
      end
      S_STOP: begin
        // Popping on the last stop tick chains frames with no idle gap.
        w_pop  = w_tick_done & ~w_empty;
        w_busy = 1'b1;
      end
      default: begin
        w_tx_nxt = 1'b1;
      end
    endcase
  end

  // Bit timing, bit index and shift register
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_tx <= w_tx_nxt;

      if (r_state == S_IDLE || w_tick_done) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end

      if (r_state == S_DATA && w_tick_done) begin
        r_bit_idx <= w_last_bit ? '0 : r_bit_idx + BIT_W'(1);
      end

      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
      end else if (r_state == S_DATA && w_tick_done) begin
        r_shift <= MSB_FIRST ? {r_shift[BYTE_WIDTH-2:0], 1'b0}
                             : {1'b0, r_shift[BYTE_WIDTH-1:1]};
      end
    end
  end

  assign uart_tx = r_tx;
  assign busy    = w_busy;

endmodule
